// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// State encoding is fixed so it can be observed and decoded consistently across the block.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int RETRY_W = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A count range of one still needs a one-bit counter.
  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Supervisor <-> PLL/core signal bundle; master is the supervisor, slave is the PLL/core side.
// All signals live in the refclk domain except pll_locked, which is synchronised inside the supervisor.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic               pll_locked;
  logic               restart;
  logic               pll_rst;
  logic               sys_reset;
  logic               lock_ok;
  logic               fail;
  logic [RETRY_W-1:0] retry_count;
  logic               lost_lock;

  modport master (
    input  pll_locked, restart,
    output pll_rst, sys_reset, lock_ok, fail, retry_count, lost_lock
  );

  modport slave (
    output pll_locked, restart,
    input  pll_rst, sys_reset, lock_ok, fail, retry_count, lost_lock
  );

endinterface

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level; latency STAGES clk edges.
// Synchronous active-low reset clears every stage so downstream logic starts from a known 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait (with bounded retries) and lock stabilisation; holds core reset until RUN.
// Outputs are Moore-decoded from the state register; lost_lock is a registered one-cycle pulse.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRIES  = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  pll_lock_supervisor_if.master sup
);

  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT);
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_clr;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lost;
  logic               lost_nxt;
  logic               locked_s;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (sup.pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state <= RESET_PLL;
      cnt   <= '0;
      retry <= '0;
      lost  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_clr ? '0 : cnt + CNT_W'(1);
      retry <= retry_nxt;
      lost  <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    lost_nxt  = 1'b0;

    if (sup.restart) begin
      state_nxt = RESET_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = STABILIZE;
          end else if (cnt == TMO_LAST) begin
            // Retry budget exhausted: park in FAIL rather than wrapping the count.
            if (retry >= RETRY_MAX) begin
              state_nxt = FAIL;
            end else begin
              retry_nxt = retry + RETRY_W'(1);
              state_nxt = RESET_PLL;
            end
          end
        end
        STABILIZE: begin
          if (!locked_s)              state_nxt = WAIT_LOCK;
          else if (cnt == STB_LAST)   state_nxt = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = RESET_PLL;
            retry_nxt = '0;
            lost_nxt  = 1'b1;
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = RESET_PLL;
        end
      endcase
    end

    // A restart while already in RESET_PLL must still rewind the hold time.
    cnt_clr = sup.restart || (state_nxt != state);
  end

  assign sup.pll_rst     = (state == RESET_PLL);
  assign sup.sys_reset   = (state != RUN);
  assign sup.lock_ok     = (state == RUN);
  assign sup.fail        = (state == FAIL);
  assign sup.retry_count = retry;
  assign sup.lost_lock   = lost;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scenarios plus randomized lock/restart/reset stimulus, checked every cycle against a phase/elapsed-time model.
module tb_pll_lock_supervisor;

  localparam int RST_C   = 4;
  localparam int STAB_C  = 8;
  localparam int TMO_C   = 32;
  localparam int RETRY_C = 2;
  localparam int SYNC_C  = 2;

  logic refclk = 1'b0;
  logic rst_n;

  pll_lock_supervisor_if bus();

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_C),
    .LOCK_STABLE  (STAB_C),
    .LOCK_TIMEOUT (TMO_C),
    .MAX_RETRIES  (RETRY_C),
    .SYNC_STAGES  (SYNC_C)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .sup    (bus)
  );

  always #10 refclk = ~refclk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which phase we are in and how long we have been in it.
  typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAIL} mphase_t;
  mphase_t m_phase = M_RST;
  int      m_el    = 0;
  int      m_retry = 0;
  bit      m_lost  = 1'b0;
  bit      m_valid = 1'b0;
  bit      sync_q[$];

  always @(posedge refclk) begin : model
    bit      ls;
    mphase_t nxt;
    if (!rst_n) begin
      m_phase = M_RST;
      m_el    = 0;
      m_retry = 0;
      m_lost  = 1'b0;
      m_valid = 1'b1;
      sync_q.delete();
      for (int i = 0; i < SYNC_C; i++) sync_q.push_back(1'b0);
    end else begin
      ls = sync_q[$];
      void'(sync_q.pop_back());
      sync_q.push_front(bus.pll_locked);
      m_lost = 1'b0;
      nxt    = m_phase;
      if (bus.restart) begin
        nxt     = M_RST;
        m_retry = 0;
      end else begin
        case (m_phase)
          M_RST:  if (m_el + 1 >= RST_C) nxt = M_WAIT;
          M_WAIT: begin
            if (ls) nxt = M_STAB;
            else if (m_el + 1 >= TMO_C) begin
              if (m_retry >= RETRY_C) nxt = M_FAIL;
              else begin
                m_retry++;
                nxt = M_RST;
              end
            end
          end
          M_STAB: begin
            if (!ls) nxt = M_WAIT;
            else if (m_el + 1 >= STAB_C) nxt = M_RUN;
          end
          M_RUN: begin
            if (!ls) begin
              nxt     = M_RST;
              m_lost  = 1'b1;
              m_retry = 0;
            end
          end
          default: ;
        endcase
      end
      m_el    = (bus.restart || nxt != m_phase) ? 0 : m_el + 1;
      m_phase = nxt;
    end
  end

  always @(negedge refclk) begin
    if (m_valid) begin
      check("pll_rst",     bus.pll_rst,     32'(m_phase == M_RST));
      check("sys_reset",   bus.sys_reset,   32'(m_phase != M_RUN));
      check("lock_ok",     bus.lock_ok,     32'(m_phase == M_RUN));
      check("fail",        bus.fail,        32'(m_phase == M_FAIL));
      check("retry_count", bus.retry_count, 32'(m_retry));
      check("lost_lock",   bus.lost_lock,   32'(m_lost));
    end
  end

  task automatic step();
    @(negedge refclk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
  endtask

  initial begin
    int hi;
    int first_ok;
    int first_fail;
    int lost_cnt;
    int lost_edge;
    int rc1_edge;
    int rc2_edge;
    int fail_cnt;
    int max_rc;
    int run_len;

    rst_n          = 1'b0;
    bus.pll_locked = 1'b1;
    bus.restart    = 1'b0;
    repeat (3) step();

    // Scenario 1: clean start with lock already present.
    check("s1_rst_pll_rst",   bus.pll_rst,     1);
    check("s1_rst_sys_reset", bus.sys_reset,   1);
    check("s1_rst_lock_ok",   bus.lock_ok,     0);
    check("s1_rst_fail",      bus.fail,        0);
    check("s1_rst_retry",     bus.retry_count, 0);
    check("s1_rst_lost",      bus.lost_lock,   0);
    rst_n    = 1'b1;
    hi       = int'(bus.pll_rst);
    first_ok = -1;
    lost_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.pll_rst) hi++;
      if (bus.lock_ok && first_ok < 0) first_ok = k;
      if (bus.lost_lock) lost_cnt++;
    end
    check("s1_pll_rst_cycles", hi, 4);
    check("s1_lock_edge", first_ok, 13);
    check("s1_lost_pulses", lost_cnt, 0);
    check("s1_sys_reset", bus.sys_reset, 0);
    check("s1_retry", bus.retry_count, 0);

    // Scenario 2: PLL never locks.
    bus.pll_locked = 1'b0;
    pulse_reset();
    first_fail = -1;
    rc1_edge   = -1;
    rc2_edge   = -1;
    fail_cnt   = 0;
    max_rc     = 0;
    for (int k = 1; k <= 330; k++) begin
      step();
      if (bus.fail) fail_cnt++;
      if (bus.fail && first_fail < 0) first_fail = k;
      if (bus.retry_count == 1 && rc1_edge < 0) rc1_edge = k;
      if (bus.retry_count == 2 && rc2_edge < 0) rc2_edge = k;
      if (int'(bus.retry_count) > max_rc) max_rc = int'(bus.retry_count);
    end
    check("s2_retry1_edge", rc1_edge, 36);
    check("s2_retry2_edge", rc2_edge, 72);
    check("s2_fail_edge", first_fail, 108);
    check("s2_fail_cycles", fail_cnt, 223);
    check("s2_max_retry", max_rc, 2);
    check("s2_pll_rst", bus.pll_rst, 0);
    check("s2_sys_reset", bus.sys_reset, 1);

    // Scenario 3: one-cycle lock glitch at stabilise count 5.
    bus.pll_locked = 1'b1;
    pulse_reset();
    first_ok = -1;
    max_rc   = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 8) bus.pll_locked = 1'b0;
      if (k == 9) bus.pll_locked = 1'b1;
      if (bus.lock_ok && first_ok < 0) first_ok = k;
      if (int'(bus.retry_count) > max_rc) max_rc = int'(bus.retry_count);
    end
    check("s3_lock_edge", first_ok, 20);
    check("s3_max_retry", max_rc, 0);

    // Scenario 4: loss of lock in RUN, then relock.
    repeat (5) step();
    bus.pll_locked = 1'b0;
    lost_cnt  = 0;
    lost_edge = -1;
    hi        = 0;
    first_ok  = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.lost_lock) begin
        lost_cnt++;
        if (lost_edge < 0) lost_edge = k;
      end
      if (bus.pll_rst) hi++;
      if (k == 3) begin
        check("s4_lock_ok_dropped", bus.lock_ok, 0);
        check("s4_sys_reset_up", bus.sys_reset, 1);
        check("s4_pll_rst_up", bus.pll_rst, 1);
        bus.pll_locked = 1'b1;
      end
      if (k > 3 && bus.lock_ok && first_ok < 0) first_ok = k;
    end
    check("s4_lost_edge", lost_edge, 3);
    check("s4_lost_pulses", lost_cnt, 1);
    check("s4_pll_rst_cycles", hi, 4);
    check("s4_relock_edge", first_ok, 16);
    check("s4_retry", bus.retry_count, 0);

    // Scenario 5: restart from RUN, then from FAIL.
    pulse_restart();
    check("s5_run_pll_rst", bus.pll_rst, 1);
    check("s5_run_no_lost", bus.lost_lock, 0);
    check("s5_run_lock_ok", bus.lock_ok, 0);
    bus.pll_locked = 1'b0;
    repeat (110) step();
    check("s5_in_fail", bus.fail, 1);
    check("s5_fail_retry", bus.retry_count, 2);
    bus.pll_locked = 1'b1;
    pulse_restart();
    check("s5_fail_cleared", bus.fail, 0);
    check("s5_retry_cleared", bus.retry_count, 0);
    check("s5_restart_pll_rst", bus.pll_rst, 1);

    // Scenario 6: reset pulse mid-STABILIZE.
    repeat (7) step();
    rst_n = 1'b0;
    step();
    check("s6_pll_rst", bus.pll_rst, 1);
    check("s6_sys_reset", bus.sys_reset, 1);
    check("s6_lock_ok", bus.lock_ok, 0);
    check("s6_fail", bus.fail, 0);
    check("s6_retry", bus.retry_count, 0);
    rst_n    = 1'b1;
    first_ok = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.lock_ok && first_ok < 0) first_ok = k;
    end
    check("s6_lock_edge", first_ok, 13);

    // Randomized lock behaviour with occasional restart and reset.
    run_len = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_len == 0) begin
        bus.pll_locked = ($urandom_range(0, 3) != 0);
        run_len        = $urandom_range(1, 40);
      end
      run_len--;
      bus.restart = ($urandom_range(0, 299) == 0);
      rst_n       = ($urandom_range(0, 499) != 0);
      step();
    end
    bus.restart = 1'b0;
    rst_n       = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sequences the system PLL through reset, lock acquisition and lock stabilisation, and gates the core reset until lock is trustworthy.
It runs on the free-running 50 MHz reference clock that also feeds the PLL, so it keeps working while PLL outputs are absent.
It retries lock on timeout, detects loss of lock during operation, and flags a permanent failure after a bounded number of retries.

Parameters:
RST_CYCLES, 16, number of cycles pll_rst is held high per attempt (min 1)
LOCK_STABLE, 1024, consecutive synchronised locked-high cycles required before release (min 1)
LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before the attempt is abandoned (min 1)
MAX_RETRIES, 3, retries after the first attempt before FAIL (0..15)
SYNC_STAGES, 2, synchroniser depth for pll_locked (min 2)

Ports:
refclk  in  1  reference clock, 50 MHz
rst_n  in  1  synchronous active-low reset
pll_locked  in  1  PLL locked, asynchronous to refclk
restart  in  1  single-cycle request to re-run the lock sequence (e.g. after reconfiguration)
pll_rst  out  1  reset to the PLL, active high
sys_reset  out  1  core reset, active high, held until stable lock
lock_ok  out  1  high only in RUN
fail  out  1  high only in FAIL
retry_count  out  4  retries used in the current sequence
lost_lock  out  1  one-cycle pulse on loss of lock while in RUN

Behaviour:
- Clocking and reset: one clock, refclk. rst_n is synchronous and active-low, sampled on the refclk rising edge.
- rst_n=0 on an edge sets:
  - state=RESET_PLL, cycle counter=0, retry_count=0, synchroniser flops=0, lost_lock=0.
  - Resulting outputs: pll_rst=1, sys_reset=1, lock_ok=0, fail=0.
- locked_s is pll_locked after SYNC_STAGES flops. All decisions use locked_s only.
- Moore outputs are decoded from the state register:
  - pll_rst=1 only in RESET_PLL.
  - sys_reset=0 only in RUN.
  - lock_ok=(state==RUN).
  - fail=(state==FAIL).
- lost_lock is a registered pulse.
- Counter: width is clog2 of the max of the three count parameters. It clears on every state change.
- Event priority: rst_n > restart > lock events.
- restart=1 in any state:
  - Go to RESET_PLL; counter=0, retry_count=0.
  - No lost_lock pulse.
  - From FAIL, this also clears fail.
- RESET_PLL: held for exactly RST_CYCLES cycles (counter 0..RST_CYCLES-1), then go to WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1: go to STABILIZE.
  - Otherwise, when counter==LOCK_TIMEOUT-1:
    - If retry_count==MAX_RETRIES, go to FAIL.
    - Else retry_count+1 and go to RESET_PLL.
- STABILIZE:
  - locked_s=0: go to WAIT_LOCK. The timeout restarts and retry_count is unchanged.
  - locked_s=1 and counter==LOCK_STABLE-1: go to RUN.
- RUN: locked_s=0 on the same edge causes all of the following:
  - Go to RESET_PLL.
  - lost_lock=1 for one cycle.
  - retry_count=0.
  - sys_reset reasserts.
- FAIL: stays in FAIL until restart or rst_n; pll_rst=0 and sys_reset=1 throughout.
- retry_count saturates at MAX_RETRIES and never wraps.
- Minimum latency from an attempt's start to lock_ok (pll_locked already high and synchroniser full) is RST_CYCLES+1+LOCK_STABLE edges.

Decomposition:
- Shared package pll_sup_pkg:
  - state encoding constants RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4 (3-bit).
  - retry_count width constant (4).
- One sub-module, sync_bit: a parameterised SYNC_STAGES-deep flop synchroniser with synchronous active-low reset, used for pll_locked.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2, SYNC_STAGES=2.
1. Start: pll_locked=1 throughout, rst_n released.
   -> pll_rst=1 for exactly 4 edges; lock_ok=1 and sys_reset=0 on edge 13 after release; retry_count=0; lost_lock never pulses.
2. Never locks: pll_locked=0 throughout.
   -> Three sequences of pll_rst (4 cycles) followed by 32 WAIT_LOCK cycles; retry_count goes 0,1,2; then FAIL with fail=1, sys_reset=1, pll_rst=0, held for 200+ cycles.
3. Glitch in STABILIZE: pll_locked drops for 1 cycle at stabilise count 5.
   -> Return to WAIT_LOCK, then a fresh 8-cycle stabilise; lock_ok is delayed by the glitch plus sync delay; retry_count stays 0.
4. Loss of lock in RUN: pll_locked deasserts.
   -> After 2 sync edges plus 1: lost_lock is high for exactly 1 cycle, lock_ok=0, sys_reset=1, pll_rst=1 for 4 cycles, retry_count=0; relock with pll_locked=1 gives lock_ok again 13 edges later.
5. restart pulse:
   - In RUN -> pll_rst is asserted next edge with no lost_lock.
   - In FAIL -> fail=0 and retry_count=0 next edge, and the sequence restarts.
6. rst_n=0 for one edge mid-STABILIZE.
   -> On that edge all outputs take reset values (pll_rst=1, sys_reset=1, lock_ok=0, fail=0, retry_count=0), and the sequence restarts from RESET_PLL.
